// File: rtl/intctl.sv
// INTCTL: 8-line rising-edge interrupt controller with fixed priority (bit 0 highest).
// Define INTCTL_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module intctl (
  input  logic       ph1,
  input  logic       reset,
  input  logic [7:0] interrupts,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       ack,
  input  logic       eoi,
  input  logic       ovf_clr,
  output logic       irq,
  output logic [2:0] vector,
  output logic [2:0] insvc,
  output logic [7:0] pending,
  output logic [7:0] overflow
);

  typedef enum logic [0:0] {StIdle, StService} state_e;

  state_e     state_q, state_d;
  logic [7:0] prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] overflow_q, overflow_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] insvc_q, insvc_d;

  logic [7:0] sampled;
  logic [7:0] rise;
  logic [7:0] enabled;
  logic [7:0] clr;
  logic       ack_take;

`ifdef INTCTL_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= interrupts;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = interrupts;
`endif

  assign rise    = sampled & ~prev_q;
  assign enabled = pending_q & mask_q;

  // Priority encoder: scan downwards so the lowest set index is the last one written.
  always_comb begin
    vector = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (enabled[i]) vector = 3'(i);
    end
  end

  assign irq      = (state_q == StIdle) && (enabled != 8'h00);
  assign ack_take = irq && ack;
  assign clr      = ack_take ? (8'h01 << vector) : 8'h00;

  // A fresh edge on the line being acknowledged re-arms it without counting as overflow.
  always_comb begin
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = (ovf_clr ? 8'h00 : overflow_q) | (rise & pending_q & ~clr);
    mask_d     = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    state_d = state_q;
    insvc_d = insvc_q;
    unique case (state_q)
      StIdle: begin
        if (ack_take) begin
          state_d = StService;
          insvc_d = vector;
        end
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      mask_q     <= '0;
      insvc_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= sampled;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      mask_q     <= mask_d;
      insvc_q    <= insvc_d;
    end
  end

  assign insvc    = insvc_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_intctl.sv
// Self-checking bench for intctl: directed vector table, reset/latency sequences,
// then randomized traffic compared against a behavioural model.
module tb_intctl;

  logic       ph1 = 1'b0;
  logic       reset;
  logic [7:0] interrupts;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic       eoi;
  logic       ovf_clr;
  logic       irq;
  logic [2:0] vector;
  logic [2:0] insvc;
  logic [7:0] pending;
  logic [7:0] overflow;

  int n_tests = 0;
  int n_fail  = 0;

  intctl dut (
    .ph1        (ph1),
    .reset      (reset),
    .interrupts (interrupts),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eoi        (eoi),
    .ovf_clr    (ovf_clr),
    .irq        (irq),
    .vector     (vector),
    .insvc      (insvc),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 ph1 = ~ph1;

  typedef struct {
    logic [7:0] intr;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       eoi;
    logic       oclr;
    logic       irq;
    logic [2:0] vec;
    logic [2:0] isv;
    logic [7:0] pend;
    logic [7:0] ovf;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  logic [7:0] m_prev, m_pend, m_ovf, m_mask, m_d1, m_d2;
  logic [2:0] m_insvc;
  logic       m_svc;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] intr, input logic mwe, input logic [7:0] mwd,
                     input logic a, input logic e, input logic oc, input logic x_irq,
                     input logic [2:0] x_vec, input logic [2:0] x_isv,
                     input logic [7:0] x_pend, input logic [7:0] x_ovf);
    vec_t v;
    v.intr = intr; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.eoi = e; v.oclr = oc;
    v.irq = x_irq; v.vec = x_vec; v.isv = x_isv; v.pend = x_pend; v.ovf = x_ovf;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [7:0] intr, input logic mwe, input logic [7:0] mwd,
                       input logic a, input logic e, input logic oc);
    interrupts = intr; mask_we = mwe; mask_wdata = mwd; ack = a; eoi = e; ovf_clr = oc;
  endtask

  task automatic check_all(input string tag, input logic x_irq, input logic [2:0] x_vec,
                           input logic [2:0] x_isv, input logic [7:0] x_pend,
                           input logic [7:0] x_ovf);
    chk({tag, " irq"},      {7'd0, irq},    {7'd0, x_irq});
    chk({tag, " vector"},   {5'd0, vector}, {5'd0, x_vec});
    chk({tag, " insvc"},    {5'd0, insvc},  {5'd0, x_isv});
    chk({tag, " pending"},  pending,        x_pend);
    chk({tag, " overflow"}, overflow,       x_ovf);
  endtask

  task automatic do_reset();
    @(negedge ph1);
    reset = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge ph1);
    #1 check_all("reset", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge ph1);
    reset = 1'b0;
    m_prev = '0; m_pend = '0; m_ovf = '0; m_mask = '0; m_d1 = '0; m_d2 = '0;
    m_insvc = '0; m_svc = 1'b0;
  endtask

  function automatic logic [2:0] model_vector();
    for (int i = 0; i < 8; i++) begin
      if (m_pend[i] && m_mask[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic logic model_irq();
    return !m_svc && ((m_pend & m_mask) != 8'h00);
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [7:0] smp, rise;
    logic [2:0] v;
    logic       take;
`ifdef INTCTL_SYNC_EN
    smp  = m_d2;
    m_d2 = m_d1;
    m_d1 = interrupts;
`else
    smp = interrupts;
`endif
    rise   = smp & ~m_prev;
    m_prev = smp;
    v      = model_vector();
    take   = model_irq() && ack;
    if (ovf_clr) m_ovf = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (rise[i] && m_pend[i] && !(take && v == 3'(i))) m_ovf[i] = 1'b1;
    end
    if (take) begin
      m_pend[v] = 1'b0;
      m_insvc   = v;
      m_svc     = 1'b1;
    end else if (m_svc && eoi) begin
      m_svc = 1'b0;
    end
    m_pend = m_pend | rise;
    if (mask_we) m_mask = mask_wdata;
  endtask

  initial begin
    reset = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check_all("async reset", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    do_reset();

`ifndef INTCTL_SYNC_EN
    //  intr   mwe  mwd    ack   eoi   oclr  irq   vec   isv   pend   ovf
    add(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 8'h00, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 8'h00, 8'h00);
    add(8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd3, 8'h22, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd1, 8'h20, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd1, 8'h20, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 8'h00, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 8'h00, 8'h00);
    add(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 8'h00, 8'h00);
    add(8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 8'h04, 8'h00);
    add(8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd5, 8'h04, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 8'h00, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 8'h00, 8'h00);
    add(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 8'h00, 8'h00);
    add(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 8'h10, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 8'h10, 8'h00);
    add(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd2, 8'h10, 8'h10);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd2, 8'h10, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 8'h00, 8'h00);
    add(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 8'h01, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd4, 8'h01, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 8'h08, 8'h00);
    add(8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 8'h08, 8'h00);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08);
    add(8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 8'h08, 8'h08);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 8'h08, 8'h00);
    add(8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 8'h0C, 8'h00);
    add(8'h00, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd2, 8'h08, 8'h00);
    add(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 8'h08, 8'h00);
    add(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd2, 8'h08, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 8'h00, 8'h00);

    foreach (tbl[i]) begin
      drive(tbl[i].intr, tbl[i].mwe, tbl[i].mwd, tbl[i].ack, tbl[i].eoi, tbl[i].oclr);
      @(posedge ph1);
      #1 check_all($sformatf("row%0d", i), tbl[i].irq, tbl[i].vec, tbl[i].isv,
                   tbl[i].pend, tbl[i].ovf);
      @(negedge ph1);
    end

    // Still in SERVICE: latch an edge, then reset asynchronously mid-cycle.
    drive(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge ph1);
    #1 check_all("svc edge", 1'b0, 3'd0, 3'd3, 8'h01, 8'h00);
    #1 reset = 1'b1;
    #1 check_all("mid-svc reset", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge ph1);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge ph1);
    reset = 1'b0;
    drive(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(posedge ph1);
    #1 check_all("post reset", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
    do_reset();
`else
    // Synchronizer build: an edge presented before clock 0 reaches irq after clock 2.
    drive(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge ph1);
    drive(8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge ph1);
      #1 chk($sformatf("sync lat c%0d irq", c), {7'd0, irq}, (c == 2) ? 8'h01 : 8'h00);
      @(negedge ph1);
      interrupts = 8'h00;
    end
    chk("sync lat vector", {5'd0, vector}, 8'h06);
    do_reset();
`endif

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 3000; n++) begin
      drive(8'($urandom), ($urandom_range(0, 19) == 0), 8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0));
      model_step();
      @(posedge ph1);
      #1 check_all($sformatf("rand%0d", n), model_irq(), model_vector(), m_insvc,
                   m_pend, m_ovf);
      @(negedge ph1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
